uart_boot_loader: RTL

//  Sequences the 9600-baud UART receiver's byte stream into a program image for instruction memory.

---
 rtl/uart_boot_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: turns the byte stream MAGIC, len[15:0], little-endian words into imem writes; holds the CPU in reset until loaded.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte over the length and data bytes.
module uart_boot_loader #(
    parameter int unsigned ADDR_W         = 12,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              byte_read,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERROR} state_t;

    // State entered once the last length/data byte has been consumed
`ifdef BOOT_CHECKSUM_EN
    localparam state_t TAIL = CHK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t           state;
    logic             byte_read_q;
    logic [15:0]      len;
    logic [15:0]      word_cnt;
    logic [1:0]       byte_idx;
    logic [7:0]       cksum;
    logic [TMO_W-1:0] tmo_cnt;

    logic        ev_c;
    logic        active_c;
    logic        timed_out_c;
    logic [15:0] len_full_c;

    assign ev_c        = byte_read & ~byte_read_q;
    assign timed_out_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    assign len_full_c  = {rx_byte, len[7:0]};
`ifdef BOOT_CHECKSUM_EN
    assign active_c = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
`else
    assign active_c = (state == LEN0) || (state == LEN1) || (state == DATA);
`endif

    // Byte-event sequencer; all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_read_q <= 1'b0;
            len         <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            cksum       <= '0;
            tmo_cnt     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            byte_read_q <= byte_read;
            mem_we      <= 1'b0;

            // Inter-byte watchdog, only while an image is in flight
            if (active_c) begin
                if (ev_c) begin
                    tmo_cnt <= '0;
                end else if (!timed_out_c) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end

            if (active_c && !ev_c && timed_out_c) begin
                state <= ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (ev_c && rx_byte == MAGIC) begin
                            state    <= LEN0;
                            busy     <= 1'b1;
                            error    <= 1'b0;
                            len      <= '0;
                            word_cnt <= '0;
                            byte_idx <= '0;
                            cksum    <= '0;
                            tmo_cnt  <= '0;
                            mem_addr <= '0;
                        end
                    end
                    LEN0: begin
                        if (ev_c) begin
                            len[7:0] <= rx_byte;
                            cksum    <= cksum ^ rx_byte;
                            state    <= LEN1;
                        end
                    end
                    LEN1: begin
                        if (ev_c) begin
                            len[15:8] <= rx_byte;
                            cksum     <= cksum ^ rx_byte;
                            if (len_full_c == 16'd0) begin
                                state <= TAIL;
                                if (TAIL == DONE) begin
                                    done <= 1'b1;
                                    busy <= 1'b0;
                                end
                            end else if (32'(len_full_c) > MAX_WORDS) begin
                                state <= ERROR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // Leave only after the final write pulse has been issued
                        if (mem_we && word_cnt == len) begin
                            state <= TAIL;
                            if (TAIL == DONE) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end else if (ev_c) begin
                            cksum                          <= cksum ^ rx_byte;
                            mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
                            byte_idx                       <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                mem_we   <= 1'b1;
                                mem_addr <= ADDR_W'(word_cnt);
                                word_cnt <= word_cnt + 16'd1;
                            end
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    CHK: begin
                        if (ev_c) begin
                            busy <= 1'b0;
                            if (rx_byte == cksum) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
`endif
                    DONE: begin
                        cpu_rst <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
